// File: rtl/red_pitaya_fads_mc_if.sv
// rtl/red_pitaya_fads_mc_if.sv - system bus bundle for the multi-channel FADS sorter
interface red_pitaya_fads_mc_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (output sys_addr, sys_wdata, sys_wen, sys_ren,
                  input  sys_rdata, sys_err, sys_ack);
  modport slave  (input  sys_addr, sys_wdata, sys_wen, sys_ren,
                  output sys_rdata, sys_err, sys_ack);
endinterface

// File: rtl/red_pitaya_fads_mc.sv
// rtl/red_pitaya_fads_mc.sv - multi-channel droplet sorter with sort queue and logger FIFO (option: FADS_TIMESTAMP_EN)
module red_pitaya_fads_mc #(
  parameter int NCH  = 2,
  parameter int DW   = 14,
  parameter int LOGD = 10,
  parameter int SQD  = 4
) (
  input  logic                adc_clk_i,
  input  logic                adc_rst_i,
  input  logic [NCH*DW-1:0]   adc_i,
  output logic                sort_trig_o,
  red_pitaya_fads_mc_if.slave bus
);
`ifdef FADS_TIMESTAMP_EN
  localparam int OFS = 2;
`else
  localparam int OFS = 1;
`endif
  localparam int ENTRY = OFS + NCH;
  localparam int DEPTH = 1 << LOGD;
  localparam int QW    = (SQD > 1) ? $clog2(SQD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACQ, S_EVAL, S_LOG} state_t;

  state_t state_q, state_d;
  logic [31:0] width_q, width_d, low_w_q, low_w_d, high_w_q, high_w_d;
  logic signed [DW-1:0] max_q [NCH], max_d [NCH];
  logic signed [DW-1:0] low_thr_q [NCH], low_thr_d [NCH], high_thr_q [NCH], high_thr_d [NCH];
  logic signed [DW-1:0] min_thr_q, min_thr_d, det;
  logic signed [DW-1:0] smp [NCH];
  logic pos_q, pos_d, log_ok_q, log_ok_d, soft_q, soft_d, acq_en_q, acq_en_d, ovf_q, ovf_d;
  logic [2:0] log_idx_q, log_idx_d;
  logic [1:0] det_ch_q, det_ch_d;
  logic [NCH-1:0] ch_en_q, ch_en_d;
  logic [31:0] sort_delay_q, sort_delay_d, sort_dur_q, sort_dur_d, ts_q, ts_d;
  logic [31:0] total_q, total_d, npos_q, npos_d, drop_sort_q, drop_sort_d, drop_log_q, drop_log_d;
  logic [LOGD-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOGD:0] fill_q, fill_d;
  logic [QW-1:0] sq_wp_q, sq_wp_d, sq_rp_q, sq_rp_d;
  logic [QW:0] sq_cnt_q, sq_cnt_d;
  logic [31:0] pulse_cnt_q, pulse_cnt_d, rdata_q, rdata_d, log_word, sq_due;
  logic trig_q, trig_d, ack_q, ack_d;
  logic wr, rd, clr, soft_eff, pop, fifo_we, sq_push, sq_pop, pos_now;
  logic [31:0] fifo_mem [DEPTH];
  logic [31:0] sq_mem [SQD];
`ifdef FADS_TIMESTAMP_EN
  logic [31:0] ts_cap_q, ts_cap_d;
`endif

  assign sort_trig_o   = trig_q;
  assign bus.sys_ack   = ack_q;
  assign bus.sys_rdata = rdata_q;
  assign bus.sys_err   = 1'b0;

  // next-state logic for bus registers, acquisition FSM, counters, FIFO and sort queue
  always_comb begin
    for (int c = 0; c < NCH; c++) smp[c] = adc_i[c*DW +: DW];
    det = smp[0];
    for (int c = 0; c < NCH; c++) if (det_ch_q == 2'(c)) det = smp[c];
    state_d = state_q; width_d = width_q; max_d = max_q; pos_d = pos_q;
    log_ok_d = log_ok_q; log_idx_d = log_idx_q;
    min_thr_d = min_thr_q; det_ch_d = det_ch_q; ch_en_d = ch_en_q;
    low_thr_d = low_thr_q; high_thr_d = high_thr_q; low_w_d = low_w_q; high_w_d = high_w_q;
    soft_d = soft_q; acq_en_d = acq_en_q; sort_delay_d = sort_delay_q; sort_dur_d = sort_dur_q;
    total_d = total_q; npos_d = npos_q; drop_sort_d = drop_sort_q; drop_log_d = drop_log_q; ovf_d = ovf_q;
    wr_ptr_d = wr_ptr_q; rd_ptr_d = rd_ptr_q;
    sq_wp_d = sq_wp_q; sq_rp_d = sq_rp_q; sq_cnt_d = sq_cnt_q;
`ifdef FADS_TIMESTAMP_EN
    ts_cap_d = ts_cap_q;
`endif
    ts_d     = ts_q + 32'd1;
    wr       = bus.sys_wen;
    rd       = bus.sys_ren;
    ack_d    = wr | rd;
    clr      = wr && (bus.sys_addr == 32'h20) && bus.sys_wdata[1];
    soft_eff = (wr && (bus.sys_addr == 32'h20)) ? bus.sys_wdata[0] : soft_q;
    pop      = rd && (bus.sys_addr == 32'h1000) && (fill_q != '0);
    fifo_we  = 1'b0;
    sq_push  = 1'b0;
    sq_due   = ts_q + sort_delay_q;
    // header word carries the decision in bit 31; peaks follow sign-extended
    log_word = {pos_q, width_q[30:0]};
`ifdef FADS_TIMESTAMP_EN
    if (log_idx_q == 3'd0) log_word = ts_cap_q;
`endif
    for (int c = 0; c < NCH; c++) if (log_idx_q == 3'(OFS + c)) log_word = 32'(max_q[c]);
    pos_now = (width_q >= low_w_q) && (width_q < high_w_q);
    for (int c = 0; c < NCH; c++)
      if (ch_en_q[c] && !((max_q[c] >= low_thr_q[c]) && (max_q[c] < high_thr_q[c]))) pos_now = 1'b0;
    sq_pop = (pulse_cnt_q == 32'd0) && (sq_cnt_q != '0) && ($signed(ts_q - sq_mem[sq_rp_q]) >= 0);

    if (wr) begin
      case (bus.sys_addr)
        32'h00: min_thr_d = bus.sys_wdata[DW-1:0];
        32'h04: det_ch_d = bus.sys_wdata[1:0];
        32'h08: ch_en_d = bus.sys_wdata[NCH-1:0];
        32'h10: low_w_d = bus.sys_wdata;
        32'h14: high_w_d = bus.sys_wdata;
        32'h20: begin soft_d = bus.sys_wdata[0]; acq_en_d = bus.sys_wdata[2]; end
        32'h24: sort_delay_d = bus.sys_wdata;
        32'h28: sort_dur_d = bus.sys_wdata;
        default: ;
      endcase
      for (int c = 0; c < NCH; c++) begin
        if (bus.sys_addr == 32'h100 + 32'(16*c)) low_thr_d[c] = bus.sys_wdata[DW-1:0];
        if (bus.sys_addr == 32'h104 + 32'(16*c)) high_thr_d[c] = bus.sys_wdata[DW-1:0];
      end
    end

    rdata_d = 32'd0;
    if (rd) begin
      case (bus.sys_addr)
        32'h000: rdata_d = 32'(min_thr_q);
        32'h004: rdata_d = {30'd0, det_ch_q};
        32'h008: rdata_d = 32'(ch_en_q);
        32'h010: rdata_d = low_w_q;
        32'h014: rdata_d = high_w_q;
        32'h020: rdata_d = {29'd0, acq_en_q, 1'b0, soft_q};
        32'h024: rdata_d = sort_delay_q;
        32'h028: rdata_d = sort_dur_q;
        32'h200: rdata_d = total_q;
        32'h204: rdata_d = npos_q;
        32'h208: rdata_d = drop_sort_q;
        32'h20C: rdata_d = drop_log_q;
        32'h210: rdata_d = {15'd0, ovf_q, 16'(fill_q)};
        32'h1000: rdata_d = pop ? fifo_mem[rd_ptr_q] : 32'd0;
        default: rdata_d = 32'd0;
      endcase
      for (int c = 0; c < NCH; c++) begin
        if (bus.sys_addr == 32'h100 + 32'(16*c)) rdata_d = 32'(low_thr_q[c]);
        if (bus.sys_addr == 32'h104 + 32'(16*c)) rdata_d = 32'(high_thr_q[c]);
      end
    end

    if (soft_eff) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE: if (acq_en_q) state_d = S_WAIT;
        S_WAIT: if (det >= min_thr_q) begin
          state_d = S_ACQ;
          width_d = 32'd1;
          for (int c = 0; c < NCH; c++) max_d[c] = smp[c];
        end
        S_ACQ: if (det < min_thr_q) state_d = S_EVAL;
        else begin
          if (width_q != '1) width_d = width_q + 32'd1;
          for (int c = 0; c < NCH; c++) if (smp[c] > max_q[c]) max_d[c] = smp[c];
        end
        S_EVAL: begin
          total_d = total_q + 32'd1;
          pos_d = pos_now;
          if (pos_now) begin
            npos_d = npos_q + 32'd1;
            if ((sq_cnt_q != (QW+1)'(SQD)) || sq_pop) sq_push = 1'b1;
            else drop_sort_d = drop_sort_q + 32'd1;
          end
          // whole entries only: reserve space for every word before starting
          log_ok_d = (fill_q <= (LOGD+1)'(DEPTH - ENTRY));
          if (fill_q > (LOGD+1)'(DEPTH - ENTRY)) begin
            drop_log_d = drop_log_q + 32'd1;
            ovf_d = 1'b1;
          end
`ifdef FADS_TIMESTAMP_EN
          ts_cap_d = ts_q;
`endif
          log_idx_d = 3'd0;
          state_d = S_LOG;
        end
        S_LOG: begin
          fifo_we = log_ok_q;
          log_idx_d = log_idx_q + 3'd1;
          if (log_idx_q == 3'(ENTRY - 1)) state_d = S_WAIT;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (fifo_we) wr_ptr_d = wr_ptr_q + LOGD'(1);
    if (pop) rd_ptr_d = rd_ptr_q + LOGD'(1);
    fill_d = fill_q + (LOGD+1)'(fifo_we) - (LOGD+1)'(pop);

    if (sq_push) sq_wp_d = sq_wp_q + QW'(1);
    if (sq_pop) sq_rp_d = sq_rp_q + QW'(1);
    sq_cnt_d = sq_cnt_q + (QW+1)'(sq_push) - (QW+1)'(sq_pop);
    if (pulse_cnt_q != 32'd0) pulse_cnt_d = pulse_cnt_q - 32'd1;
    else if (sq_pop) pulse_cnt_d = sort_dur_q;
    else pulse_cnt_d = 32'd0;
    if (soft_eff) begin
      sq_wp_d = '0; sq_rp_d = '0; sq_cnt_d = '0; pulse_cnt_d = 32'd0;
    end
    trig_d = (pulse_cnt_d != 32'd0);

    if (clr) begin
      total_d = '0; npos_d = '0; drop_sort_d = '0; drop_log_d = '0; ovf_d = 1'b0;
    end
  end

  // storage arrays are plain RAM: written without reset
  always_ff @(posedge adc_clk_i) begin
    if (fifo_we) fifo_mem[wr_ptr_q] <= log_word;
    if (sq_push) sq_mem[sq_wp_q] <= sq_due;
  end

  // state register bank
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      state_q <= S_IDLE; width_q <= '0; pos_q <= 1'b0; log_ok_q <= 1'b0; log_idx_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        max_q[c] <= '0; low_thr_q[c] <= DW'(16); high_thr_q[c] <= DW'(255);
      end
      min_thr_q <= DW'(15); det_ch_q <= '0; ch_en_q <= '1; low_w_q <= 32'd1; high_w_q <= '1;
      soft_q <= 1'b0; acq_en_q <= 1'b1; sort_delay_q <= 32'd31250; sort_dur_q <= 32'd125000;
      total_q <= '0; npos_q <= '0; drop_sort_q <= '0; drop_log_q <= '0; ovf_q <= 1'b0; ts_q <= '0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; fill_q <= '0;
      sq_wp_q <= '0; sq_rp_q <= '0; sq_cnt_q <= '0; pulse_cnt_q <= '0;
      trig_q <= 1'b0; ack_q <= 1'b0; rdata_q <= '0;
`ifdef FADS_TIMESTAMP_EN
      ts_cap_q <= '0;
`endif
    end else begin
      state_q <= state_d; width_q <= width_d; pos_q <= pos_d; log_ok_q <= log_ok_d; log_idx_q <= log_idx_d;
      max_q <= max_d; low_thr_q <= low_thr_d; high_thr_q <= high_thr_d;
      min_thr_q <= min_thr_d; det_ch_q <= det_ch_d; ch_en_q <= ch_en_d; low_w_q <= low_w_d; high_w_q <= high_w_d;
      soft_q <= soft_d; acq_en_q <= acq_en_d; sort_delay_q <= sort_delay_d; sort_dur_q <= sort_dur_d;
      total_q <= total_d; npos_q <= npos_d; drop_sort_q <= drop_sort_d; drop_log_q <= drop_log_d;
      ovf_q <= ovf_d; ts_q <= ts_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; fill_q <= fill_d;
      sq_wp_q <= sq_wp_d; sq_rp_q <= sq_rp_d; sq_cnt_q <= sq_cnt_d; pulse_cnt_q <= pulse_cnt_d;
      trig_q <= trig_d; ack_q <= ack_d; rdata_q <= rdata_d;
`ifdef FADS_TIMESTAMP_EN
      ts_cap_q <= ts_cap_d;
`endif
    end
  end
endmodule

// File: doc/red_pitaya_fads_mc.md
Name: red_pitaya_fads_mc

Overview:
Multi-channel successor of the single-channel FADS sorter. One detection channel qualifies droplets; peak intensity is tracked on all NCH fast-ADC channels. Per-channel and width gates make the sort decision. Positive decisions enter a sort queue, so several droplets can be in flight between detector and electrode, and every droplet is written to a pop-on-read logger FIFO. Sits on the ADC clock between the ADC inputs, the ASG trigger and the system bus.

Parameters:
NCH, 2, number of ADC channels evaluated (1..4)
DW, 14, signed ADC sample width
LOGD, 10, log2 of logger FIFO depth in 32-bit words
SQD, 4, sort-queue depth (pending sorts), power of two

Ports:
adc_clk_i  in  1  ADC clock, single clock domain
adc_rst_i  in  1  reset, asynchronous, active-high
adc_i  in  NCH*DW  signed samples, channel c at bits [c*DW +: DW]
sort_trig_o  out  1  sort pulse to ASG trigger
sys_addr  in  32  bus address
sys_wdata  in  32  bus write data
sys_wen  in  1  bus write enable
sys_ren  in  1  bus read enable
sys_rdata  out  32  bus read data
sys_err  out  1  bus error, tied 0
sys_ack  out  1  bus acknowledge

Behaviour:
- Reset (adc_rst_i=1, async): FSM IDLE, sort_trig_o=0, sys_ack=0, sys_err=0, sys_rdata=0, queue and FIFO empty, counters 0, timestamp 0, registers at defaults.
- Register defaults: min_thr=15, det_ch=0, ch_en=all ones, low_thr_c=16, high_thr_c=255, low_w=1, high_w=0xFFFFFFFF, sort_delay=31250, sort_duration=125000.
- Bus: sys_ack registered one cycle after sys_wen|sys_ren, on any address. Unmapped reads return 0. Writes to read-only addresses are ignored.
- Register map: 0x00 min_thr, 0x04 det_ch, 0x08 ch_en, 0x10 low_w, 0x14 high_w, 0x20 ctrl, 0x24 sort_delay, 0x28 sort_duration.
  - ctrl bit0 soft_reset (level), bit1 counter clear (self-clearing), bit2 acq_en (default 1).
  - 0x100+0x10*c: low_thr_c. 0x104+0x10*c: high_thr_c. Thresholds are signed DW bits, sign-extended on read.
  - 0x200 total, 0x204 positive, 0x208 dropped_sorts, 0x20C dropped_logs counters.
  - 0x210 status: [LOGD:0] FIFO fill, bit16 overflow sticky (cleared by counter clear).
  - 0x1000 LOG_DATA: each read pops one word. Reading when empty returns 0 and does not pop.
- Timestamp: free-running 32-bit counter, wraps.
- FSM states:
  - IDLE -> WAIT when acq_en && !soft_reset.
  - WAIT -> ACQ when det sample >= min_thr. Width loads 1, max_c loads the current samples.
  - ACQ: width +1 per cycle, saturating at 0xFFFFFFFF; max_c updated on signed greater-than. Exits to EVAL on the first cycle with det < min_thr; that sample is not counted.
  - EVAL (1 cycle): positive = low_w <= width < high_w AND, for every c with ch_en[c], low_thr_c <= max_c < high_thr_c. total +1; positive +1 if positive. -> LOG.
  - LOG: writes 1+NCH words over 1+NCH cycles. Word 0 = {positive, width[30:0]}; then max_c sign-extended. If free space < 1+NCH at EVAL, the entry is skipped, dropped_logs +1 and overflow set; no partial entries are ever written. -> WAIT.
- Sort queue: on positive in EVAL, push due = timestamp + sort_delay. If the queue is full, the push is skipped and dropped_sorts +1.
- Pulse: when not pulsing and the queue is non-empty, the head pops once (timestamp - due) as signed 32-bit is >= 0. sort_trig_o is then high for exactly sort_duration cycles. A pulse with sort_duration=0 pops without asserting.
- Back-to-back: a due entry waits until the current pulse ends, then starts on the next cycle.
- Soft reset (any state): FSM -> IDLE, queue flushed, sort_trig_o=0 next cycle. Counters, FIFO and registers keep their values.
- Simultaneous push and pop on the queue in one cycle is legal; a full queue with a same-cycle pop accepts the push.
- Simultaneous FIFO write and bus pop is legal; fill stays consistent.

Optional Feature:
FADS_TIMESTAMP_EN. Defined: each log entry is prefixed with the 32-bit timestamp captured at EVAL, so an entry is 2+NCH words and the free-space check uses 2+NCH. Undefined: no timestamp word, entry is 1+NCH words.

Test Plan:
- NCH=2, det ch0 at 100 for 20 cycles, ch1 peak 50, thresholds 16..255 -> total=1, positive=1, FIFO fill=3, words {1,20}, 100, 50.
- Same droplet with ch1 peak 300 and ch_en=3 -> positive=0, no pulse. Repeat with ch_en=1 -> positive=1.
- sort_delay=10, sort_duration=5, three positives 4 cycles apart -> three 5-cycle pulses; 2nd and 3rd start back-to-back after the previous pulse ends.
- SQD=4, five positives within the delay window -> four pulses, dropped_sorts=1.
- LOGD=3 (8 words), NCH=2, three droplets with no reads -> two logged, dropped_logs=1, overflow=1. Six LOG_DATA reads -> fill=0; a 7th read returns 0.
- Soft reset asserted mid-pulse with two entries queued -> sort_trig_o low next cycle, no further pulses, counters unchanged. Async adc_rst_i mid-ACQ -> all outputs at reset values immediately.
